// File: rtl/mux_arb_4x1_pkg.sv
// Shared types and the round-robin pick helper for the mux_arb_4x1 arbiter.
// Used by the arbiter core regardless of whether ARB_HOLD_LIMIT_EN is defined.
package mux_arb_4x1_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan from the highest index down so the first hit in ptr order is the one kept.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] cand,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t            r;
        logic [SEL_W-1:0] idx;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (cand[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_4x1_mux.sv
// Plain N-bit 4:1 payload multiplexer, select driven by the arbiter's sel register.
module mux_nbit_4x1 #(
    parameter int N = 32
) (
    input  logic [1:0]   i_sel,
    input  logic [N-1:0] i_d0,
    input  logic [N-1:0] i_d1,
    input  logic [N-1:0] i_d2,
    input  logic [N-1:0] i_d3,
    output logic [N-1:0] o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            2'd3:    o_y = i_d3;
            default: o_y = i_d0;
        endcase
    end

endmodule

// File: rtl/mux_arb_4x1.sv
// Round-robin 4-requester arbiter with transaction hold and payload mux.
// Define ARB_HOLD_LIMIT_EN to add the MAX_HOLD grant limit and timeout pulse.
module mux_arb_4x1
    import mux_arb_4x1_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [3:0]   last,
    input  logic [N-1:0] data0,
    input  logic [N-1:0] data1,
    input  logic [N-1:0] data2,
    input  logic [N-1:0] data3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         busy,
    output logic         timeout
);

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0] w_cand;
    logic [SEL_W-1:0]   w_pick_ptr;
    pick_t              w_pick;
    logic               w_end;
    logic               w_hit;
    logic               w_new_grant;

    // In the end cycle the outgoing requester is excluded and priority starts just past it.
    assign w_cand     = (r_state == GRANT) ? (req & ~r_gnt) : req;
    assign w_pick_ptr = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;
    assign w_pick     = rr_pick(w_cand, w_pick_ptr);

    assign w_end = (r_state == GRANT) &&
                   ((req[r_sel] && last[r_sel]) || !req[r_sel] || w_hit);

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] r_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_new_grant) begin
            r_hold <= '0;
        end else if (r_state == GRANT) begin
            r_hold <= r_hold + 8'd1;
        end
    end

    assign w_hit = (r_state == GRANT) && (r_hold == 8'(MAX_HOLD - 1));
`else
    logic [7:0] w_unused_hold;
    assign w_unused_hold = 8'(MAX_HOLD);
    assign w_hit         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_new_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick.found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = NUM_REQ'(1) << w_pick.idx;
                    w_sel_nxt   = w_pick.idx;
                    w_new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (w_end) begin
                    w_ptr_nxt = r_sel + SEL_W'(1);
                    if (w_pick.found) begin
                        w_gnt_nxt   = NUM_REQ'(1) << w_pick.idx;
                        w_sel_nxt   = w_pick.idx;
                        w_new_grant = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    mux_nbit_4x1 #(.N(N)) u_mux (
        .i_sel (r_sel),
        .i_d0  (data0),
        .i_d1  (data1),
        .i_d2  (data2),
        .i_d3  (data3),
        .o_y   (out_data)
    );

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = (r_state == GRANT);
    assign out_valid = busy && |(r_gnt & req);
    assign timeout   = w_hit;

endmodule

// File: tb/tb_mux_arb_4x1.sv
// Scoreboard bench for mux_arb_4x1: a reference model queues expected outputs per cycle.
// Build with or without ARB_HOLD_LIMIT_EN; the model follows the same macro.
module tb_mux_arb_4x1;

    localparam int N        = 32;
    localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HL = 1'b1;
`else
    localparam bit HL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req, last;
    logic [N-1:0] data0, data1, data2, data3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [N-1:0] out_data;
    logic         out_valid, busy, timeout;

    always #5 clk = ~clk;

    mux_arb_4x1 #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } reg_exp_t;

    typedef struct {
        logic [N-1:0] data;
        logic         vld;
        logic         to;
    } comb_exp_t;

    reg_exp_t  rq[$];
    comb_exp_t cq[$];
    int n_checks = 0;
    int n_pass   = 0;

    bit         m_busy;
    logic [3:0] m_gnt;
    logic [1:0] m_sel;
    logic [1:0] m_ptr;
    int         m_hold;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Returns {found, index} of the first set bit of c scanning start, start+1, ...
    function automatic logic [2:0] find_rr(input logic [3:0] c, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!res[2] && c[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [N-1:0] data_of(input logic [1:0] s);
        case (s)
            2'd0:    return data0;
            2'd1:    return data1;
            2'd2:    return data2;
            default: return data3;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0] f;
        bit         ended;
        if (rst) begin
            m_busy = 0; m_gnt = 4'b0; m_sel = 2'd0; m_ptr = 2'd0; m_hold = 0;
        end else if (!m_busy) begin
            f = find_rr(req, m_ptr);
            if (f[2]) begin
                m_busy = 1; m_sel = f[1:0]; m_gnt = 4'b0001 << f[1:0]; m_hold = 0;
            end
        end else begin
            ended = (req[m_sel] && last[m_sel]) || !req[m_sel] ||
                    (HL && m_hold == MAX_HOLD - 1);
            if (ended) begin
                m_ptr = m_sel + 2'd1;
                f = find_rr(req & ~m_gnt, m_ptr);
                if (f[2]) begin
                    m_sel = f[1:0]; m_gnt = 4'b0001 << f[1:0]; m_hold = 0;
                end else begin
                    m_busy = 0; m_gnt = 4'b0;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic pop_comb();
        comb_exp_t ce;
        check_eq("sb_comb_depth", 32'(cq.size()), 32'd1);
        if (cq.size() > 0) begin
            ce = cq.pop_front();
            check_eq("out_data", out_data, ce.data);
            check_eq("out_valid", 32'(out_valid), 32'(ce.vld));
            check_eq("timeout", 32'(timeout), 32'(ce.to));
        end
    endtask

    task automatic pop_reg();
        reg_exp_t re;
        check_eq("sb_reg_depth", 32'(rq.size()), 32'd1);
        if (rq.size() > 0) begin
            re = rq.pop_front();
            check_eq("gnt", 32'(gnt), 32'(re.gnt));
            check_eq("sel", 32'(sel), 32'(re.sel));
            check_eq("busy", 32'(busy), 32'(re.busy));
        end
    endtask

    // One clock: drive inputs, check combinational outputs, then registered state after the edge.
    task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rs);
        comb_exp_t ce;
        reg_exp_t  re;
        rst   = rs;
        req   = r;
        last  = l;
        data0 = $urandom;
        data1 = $urandom;
        data2 = $urandom;
        data3 = $urandom;
        ce.data = data_of(m_sel);
        ce.vld  = m_busy && r[m_sel];
        ce.to   = HL && m_busy && (m_hold == MAX_HOLD - 1);
        cq.push_back(ce);
        #1;
        pop_comb();
        model_step();
        re.gnt  = m_gnt;
        re.sel  = m_sel;
        re.busy = m_busy;
        rq.push_back(re);
        @(posedge clk);
        #1;
        pop_reg();
    endtask

    logic [3:0] exp_seq [5];

    initial begin
        rst = 1'b1; req = 4'b0; last = 4'b0;
        data0 = $urandom; data1 = $urandom; data2 = $urandom; data3 = $urandom;
        repeat (2) @(posedge clk);
        #1;
        model_step();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_data", out_data, data0);

        // Single requester 2, last on its third granted cycle
        cyc(4'b0100, 4'b0000, 1'b0);
        check_eq("t1_gnt", 32'(gnt), 32'b0100);
        check_eq("t1_sel", 32'(sel), 32'd2);
        check_eq("t1_data", out_data, data2);
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0100, 1'b0);
        check_eq("t1_end_gnt", 32'(gnt), 32'd0);

        // All requesting, one beat each; pointer left at 3 starts the rotation there
        exp_seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 4'b1111, 1'b0);
            check_eq($sformatf("t2_rr%0d", i), 32'(gnt), 32'(exp_seq[i]));
        end
        cyc(4'b0000, 4'b0000, 1'b0);

        // Requester 1 aborts; pending 0 and 3, search starts at 2 -> 3
        cyc(4'b0010, 4'b0000, 1'b0);
        check_eq("t3_gnt1", 32'(gnt), 32'b0010);
        cyc(4'b0010, 4'b0000, 1'b0);
        cyc(4'b1001, 4'b0000, 1'b0);
        check_eq("t3_abort_gnt", 32'(gnt), 32'b1000);
        cyc(4'b0000, 4'b0000, 1'b0);

        // last from a non-granted requester is ignored
        cyc(4'b0001, 4'b0000, 1'b0);
        check_eq("t6_gnt0", 32'(gnt), 32'b0001);
        cyc(4'b0101, 4'b0100, 1'b0);
        check_eq("t6_hold_gnt", 32'(gnt), 32'b0001);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Reset mid-transaction with sel=3
        cyc(4'b1000, 4'b0000, 1'b0);
        check_eq("t4_sel3", 32'(sel), 32'd3);
        cyc(4'b1000, 4'b0000, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b1);
        check_eq("t4_rst_gnt", 32'(gnt), 32'd0);
        check_eq("t4_rst_busy", 32'(busy), 32'd0);
        check_eq("t4_rst_sel", 32'(sel), 32'd0);
        cyc(4'b1111, 4'b0000, 1'b0);
        check_eq("t4_after_gnt", 32'(gnt), 32'b0001);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Requester 0 never signals last
        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0011, 4'b0000, 1'b0);
        check_eq("t5_gnt0", 32'(gnt), 32'b0001);
        for (int i = 0; i < 4; i++) cyc(4'b0011, 4'b0000, 1'b0);
        check_eq("t5_limit_gnt", 32'(gnt), HL ? 32'b0010 : 32'b0001);
        for (int i = 0; i < 12; i++) cyc(4'b0011, 4'b0000, 1'b0);
        check_eq("t5_long_gnt", 32'(gnt), 32'b0001);
        cyc(4'b0000, 4'b0000, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc(4'($urandom), 4'($urandom), ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_arb_4x1.md
# mux_arb_4x1

Round-robin arbiter and payload selector that shares one N-bit datapath between four requesters. Picks one requester at a time, holds the grant for a multi-cycle transaction until the requester signals its last beat, and drives the selected payload through an internal 4:1 N-bit mux. Sits in front of any shared single-port resource (bus, memory port, writeback path).

## Interface
- N, 32, payload width per requester
- MAX_HOLD, 16, max cycles one grant may be held; only used when the hold limit is compiled in; legal range 2..255
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  per-requester request; must stay high for the whole transaction
- last  in  4  per-requester end-of-transaction flag; sampled only for the granted requester while its req is high
- data0, data1, data2, data3  in  N each  requester payloads
- gnt  out  4  registered one-hot grant, 0 when idle
- sel  out  2  registered index of the granted requester; drives the mux select
- out_data  out  N  payload of requester sel (combinational through the mux)
- out_valid  out  1  gnt active and granted requester's req high
- busy  out  1  state is GRANT
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit; constant 0 when the limit is compiled out

## Operation
- States: IDLE, GRANT. Pointer ptr[1:0] = highest-priority requester for the next pick.
- Pick: first set bit of the candidate vector searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if req != 0, pick from req; register gnt/sel; go GRANT. Else stay.
- GRANT end event: req[sel] & last[sel] (normal end), or req[sel] == 0 (abort), or hold limit hit.
- On end: ptr <= sel+1 (mod 4); candidates = req & ~gnt; if nonzero, register new pick and stay GRANT (back-to-back, no idle bubble); else gnt <= 0 and go IDLE. sel keeps its last value in IDLE.
- No end event: gnt, sel, ptr unchanged; req/last of other requesters ignored.
- Candidate exclusion applies only to the end cycle; an ended requester re-requesting is eligible at the next pick, lowest priority.
- Hold counter: cleared on every new grant, increments each GRANT cycle; the end event fires in the cycle the counter equals MAX_HOLD-1.
- out_valid = busy & |(gnt & req).

## Timing
- Reset: state IDLE, gnt 0, sel 0, ptr 0, hold counter 0, busy 0, out_valid 0, timeout 0; out_data = data0.
- Arbitration latency: req rising in cycle t from IDLE -> gnt/busy high in t+1.
- Handover: end event in cycle t -> new gnt in t+1; old gnt low in t+1.
- out_data follows sel and data combinationally, zero latency.
- rst during GRANT: all state to reset values the next edge; in-flight transaction dropped, ptr back to 0.
- Multiple simultaneous req: exactly one grant; starvation bound 3 transactions.

## Configuration
- ARB_HOLD_LIMIT_EN defined: hold counter and timeout pulse present; grant forcibly ended after MAX_HOLD cycles, timeout high for the end cycle, ptr advances as a normal end.
- Undefined: no counter; grant held until last or req drop; timeout tied 0; MAX_HOLD ignored.

## Structure
- Shared package: state enum (IDLE, GRANT), NUM_REQ = 4, SEL_W = 2, rr-pick function (4-bit candidate, 2-bit ptr -> 2-bit index + found flag).
- One sub-module: mux_nbit_4x1 (N) for the payload, select driven by sel; arbitration FSM, pointer and hold counter live in this block.

## Test plan
- Reset then req=4'b0100 held, last on 3rd granted cycle -> gnt=0100, sel=2 one cycle after req; out_data=data2; gnt=0 cycle after last; ptr=3.
- req=4'b1111 constantly, each grant lasts 1 beat (last=1111) -> grants 0001,0010,0100,1000,0001 on consecutive cycles, no bubbles.
- Granted requester 1 drops req without last -> treated as end; next cycle grant to next pending requester (req=4'b1001 -> 1000).
- rst asserted mid-transaction with sel=3 -> next cycle gnt=0, busy=0, sel=0; then req=1111 -> gnt=0001.
- ARB_HOLD_LIMIT_EN, MAX_HOLD=4, requester 0 never asserts last, req=0011 -> timeout pulse on 4th granted cycle, gnt=0010 next cycle; undefined build -> gnt stays 0001 indefinitely.
- last asserted by a non-granted requester (last=0100 while sel=0) -> ignored, grant unchanged.
